// File: rtl/fb_pkg.sv
// fb_pkg: shared constants for the framebuffer rectangle-fill engine.
//   - FSM state encodings
//   - register word indices
//   - CTRL/STATUS bit positions
//   - default geometry parameters
//   - the clipping helper
package fb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_ORIGIN = 3'd2;
    localparam logic [2:0] REG_SIZE   = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;
    localparam logic [2:0] REG_STEP   = 3'd5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;

    localparam logic [29:0] FB_BASE_W_DEF = 30'h04100000;
    localparam int unsigned ROW_SHIFT_DEF = 10;
    localparam int unsigned MAX_W_DEF     = 800;
    localparam int unsigned MAX_H_DEF     = 600;

    // Clipped extent: min(size, lim - org). It is 0 when the origin is at or past lim.
    function automatic logic [10:0] clip_extent(input logic [10:0] size, input logic [9:0] org,
                                                input logic [10:0] lim);
        logic [10:0] rem;
        rem = ({1'b0, org} >= lim) ? 11'd0 : lim - {1'b0, org};
        return (size < rem) ? size : rem;
    endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// fb_raster_counter: column/row counters that walk a clipped rectangle in raster order.
// Ports:
//   clk      - clock
//   clear    - synchronous clear of the counters and the latched extents
//   load     - latch ew/eh and restart at (0,0)
//   ew, eh   - clipped width/height, captured on load
//   advance  - step to the next pixel (one accepted beat)
//   last_col - current column is the last one of the row
//   last_pix - current pixel is the last one of the rectangle
//   offset   - word offset from the origin: (row << ROW_SHIFT) + col
module fb_raster_counter #(
    parameter int unsigned ROW_SHIFT = 10
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [10:0] ew,
    input  logic [10:0] eh,
    input  logic        advance,
    output logic        last_col,
    output logic        last_pix,
    output logic [29:0] offset
);

    logic [10:0] col_q;
    logic [10:0] row_q;
    logic [10:0] ew_q;
    logic [10:0] eh_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            col_q <= '0;
            row_q <= '0;
            ew_q  <= '0;
            eh_q  <= '0;
        end else if (load) begin
            col_q <= '0;
            row_q <= '0;
            ew_q  <= ew;
            eh_q  <= eh;
        end else if (advance) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= row_q + 11'd1;
            end else begin
                col_q <= col_q + 11'd1;
            end
        end
    end

    assign last_col = (col_q == ew_q - 11'd1);
    assign last_pix = last_col && (row_q == eh_q - 11'd1);
    assign offset   = (30'(row_q) << ROW_SHIFT) + 30'(col_q);

endmodule

// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: memory-mapped rectangle-fill engine for the framebuffer.
// Optional feature: define FB_FILL_GRAD_EN to add the STEP register. Each accepted pixel then
// advances the colour by STEP. Without it every beat carries COLOR.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_we/addr/wdata - register write port (word index in cfg_addr)
//   cfg_rdata         - combinational read of the register at cfg_addr
//   wr_valid/ready    - framebuffer write handshake
//   wr_addr, wr_data  - word address and pixel value of the current beat
//   busy              - fill engine not idle
//   done              - one-cycle pulse when a fill completes or is aborted
module fb_fill_ctrl
    import fb_pkg::*;
#(
    parameter logic [29:0] FB_BASE_W = FB_BASE_W_DEF,
    parameter int unsigned ROW_SHIFT = ROW_SHIFT_DEF,
    parameter int unsigned MAX_W     = MAX_W_DEF,
    parameter int unsigned MAX_H     = MAX_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [29:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [10:0] MAX_W_L = 11'(MAX_W);
    localparam logic [10:0] MAX_H_L = 11'(MAX_H);

    logic [1:0]  state_q;
    logic [9:0]  org_x_q;
    logic [9:0]  org_y_q;
    logic [10:0] size_w_q;
    logic [10:0] size_h_q;
    logic [31:0] color_q;
    logic        done_sticky_q;
    logic        aborted_q;
    logic        abort_pend_q;
`ifdef FB_FILL_GRAD_EN
    logic [31:0] step_q;
    logic [31:0] pix_q;
`endif

    logic        ctrl_wr;
    logic        start_req;
    logic        abort_wr;
    logic        handshake;
    logic [10:0] ew;
    logic [10:0] eh;
    logic        last_col;
    logic        last_pix;
    logic [29:0] offset;

    assign ctrl_wr   = cfg_we && (cfg_addr == REG_CTRL);
    // Abort has priority: start and abort in the same write starts nothing.
    assign start_req = ctrl_wr && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT];
    assign abort_wr  = ctrl_wr && cfg_wdata[CTRL_ABORT];

    assign ew = clip_extent(size_w_q, org_x_q, MAX_W_L);
    assign eh = clip_extent(size_h_q, org_y_q, MAX_H_L);

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign wr_valid  = (state_q == ST_RUN);
    assign handshake = wr_valid && wr_ready;

    fb_raster_counter #(
        .ROW_SHIFT (ROW_SHIFT)
    ) u_counter (
        .clk      (clk),
        .clear    (rst),
        .load     (start_req && (state_q == ST_IDLE)),
        .ew       (ew),
        .eh       (eh),
        .advance  (handshake),
        .last_col (last_col),
        .last_pix (last_pix),
        .offset   (offset)
    );

    // The address is driven straight from the registers and counters, so it reads FB_BASE_W
    // after reset and stays put while a beat waits for ready.
    assign wr_addr = FB_BASE_W + (30'(org_y_q) << ROW_SHIFT) + 30'(org_x_q) + offset;
`ifdef FB_FILL_GRAD_EN
    assign wr_data = pix_q;
`else
    assign wr_data = color_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            org_x_q       <= '0;
            org_y_q       <= '0;
            size_w_q      <= '0;
            size_h_q      <= '0;
            color_q       <= '0;
            done_sticky_q <= 1'b0;
            aborted_q     <= 1'b0;
            abort_pend_q  <= 1'b0;
`ifdef FB_FILL_GRAD_EN
            step_q        <= '0;
            pix_q         <= '0;
`endif
        end else begin
            if (cfg_we && !busy) begin
                case (cfg_addr)
                    REG_ORIGIN: begin
                        org_x_q <= cfg_wdata[9:0];
                        org_y_q <= cfg_wdata[25:16];
                    end
                    REG_SIZE: begin
                        size_w_q <= cfg_wdata[10:0];
                        size_h_q <= cfg_wdata[26:16];
                    end
                    REG_COLOR: color_q <= cfg_wdata;
`ifdef FB_FILL_GRAD_EN
                    REG_STEP:  step_q <= cfg_wdata;
`endif
                    default: ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        done_sticky_q <= 1'b0;
                        aborted_q     <= 1'b0;
                        abort_pend_q  <= 1'b0;
`ifdef FB_FILL_GRAD_EN
                        pix_q         <= color_q;
`endif
                        state_q <= ((ew == 11'd0) || (eh == 11'd0)) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_wr) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (handshake) begin
`ifdef FB_FILL_GRAD_EN
                        pix_q <= pix_q + step_q;
`endif
                        // Valid is always high in RUN, so a latched abort waits for the
                        // outstanding beat to be accepted before it takes effect.
                        if (abort_pend_q || last_pix) begin
                            state_q      <= ST_FINISH;
                            aborted_q    <= abort_pend_q;
                            abort_pend_q <= 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    done_sticky_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_STATUS: begin
                cfg_rdata[STAT_BUSY]    = busy;
                cfg_rdata[STAT_DONE]    = done_sticky_q;
                cfg_rdata[STAT_ABORTED] = aborted_q;
            end
            REG_ORIGIN: cfg_rdata = {6'b0, org_y_q, 6'b0, org_x_q};
            REG_SIZE:   cfg_rdata = {5'b0, size_h_q, 5'b0, size_w_q};
            REG_COLOR:  cfg_rdata = color_q;
`ifdef FB_FILL_GRAD_EN
            REG_STEP:   cfg_rdata = step_q;
`endif
            default:    cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Scoreboard bench for fb_fill_ctrl: fills are modelled from the clipping/raster rules into an
// expected-event queue; a monitor pops and compares on every presented beat and done pulse.
module tb_fb_fill_ctrl;

    localparam int FB_BASE = 32'h04100000;
`ifdef FB_FILL_GRAD_EN
    localparam bit GRAD = 1'b1;
`else
    localparam bit GRAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [29:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    typedef struct {
        bit          is_done;
        bit          after_beat;
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   hs_count = 0;
    int   hs_limit = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: ready until hs_limit beats
    int   neg_cnt = 0;
    int   last_hs = 0;

    fb_fill_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] e);
        cfg_addr = a;
        #1;
        check(name, 64'(cfg_rdata), 64'(e));
        cfg_addr = '0;
    endtask

    // Reference model: clip, then emit up to max_beats pixels in raster order, then done.
    task automatic model_fill(input int x, input int y, input int w, input int h,
                              input logic [31:0] color, input logic [31:0] step,
                              input int max_beats, output int n);
        int   ew, eh;
        exp_t e;
        ew = (x >= 800) ? 0 : 800 - x;
        if (w < ew) ew = w;
        eh = (y >= 600) ? 0 : 600 - y;
        if (h < eh) eh = h;
        n = 0;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                if (n < max_beats) begin
                    e.is_done    = 1'b0;
                    e.after_beat = 1'b0;
                    e.addr       = 30'(FB_BASE + (y + r) * 1024 + x + c);
                    e.data       = GRAD ? color + 32'(n) * step : color;
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
        e.is_done    = 1'b1;
        e.after_beat = (n > 0);
        e.addr       = '0;
        e.data       = '0;
        exp_q.push_back(e);
    endtask

    task automatic start_fill(input int x, input int y, input int w, input int h,
                              input logic [31:0] color, input logic [31:0] step,
                              input int max_beats);
        int n;
        cfg_write(3'd2, {6'b0, 10'(y), 6'b0, 10'(x)});
        cfg_write(3'd3, {5'b0, 11'(h), 5'b0, 11'(w)});
        cfg_write(3'd4, color);
        cfg_write(3'd5, step);
        model_fill(x, y, w, h, color, step, max_beats, n);
        cfg_write(3'd0, 32'h1);
        check("busy_after_start", 64'(busy), 64'(1));
        check("valid_after_start", 64'(wr_valid), 64'(n > 0));
        if (n == 0) check("zero_area_done_n1", 64'(done), 64'(1));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("fill_complete_in_budget", 64'(exp_q.size() == 0 && !busy), 64'(1));
    endtask

    // Ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = (hs_count < hs_limit);
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t f;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst) begin
                exp_q.delete();
            end else begin
                if (wr_valid) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        check("unexpected_beat", 64'(wr_addr), 64'h3fffffff_00000000);
                    end else begin
                        f = exp_q[0];
                        check("beat_addr", 64'(wr_addr), 64'(f.addr));
                        check("beat_data", 64'(wr_data), 64'(f.data));
                        if (wr_ready) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                            last_hs = neg_cnt;
                        end
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        check("unexpected_done", 64'(exp_q.size()), 64'(0));
                    end else begin
                        f = exp_q.pop_front();
                        if (f.after_beat) check("done_after_last_beat", 64'(neg_cnt - last_hs), 64'(1));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
                 n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        logic [31:0] col_a;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(wr_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_addr", 64'(wr_addr), 64'h04100000);
        check("rst_data", 64'(wr_data), 64'(0));
        read_check("rst_status", 3'd1, 32'h0);
        read_check("rst_color", 3'd4, 32'h0);

        // Basic 4x2 fill.
        ready_mode = 0;
        start_fill(0, 0, 4, 2, 32'h00FF0000, 32'h0, 1 << 30);
        wait_done(100);
        read_check("basic_status", 3'd1, 32'h2);
        read_check("basic_size", 3'd3, 32'h0002_0004);
        read_check("ctrl_reads_zero", 3'd0, 32'h0);
        read_check("unmapped_reads_zero", 3'd7, 32'h0);

        // Backpressure 3x3.
        ready_mode = 1;
        start_fill(5, 7, 3, 3, $urandom, 32'h0, 1 << 30);
        wait_done(200);

        // Clipping at the bottom-right corner.
        start_fill(798, 599, 10, 10, 32'h12345678, 32'h0, 1 << 30);
        wait_done(100);

        // Zero-area fills.
        start_fill(10, 10, 0, 5, 32'h1, 32'h0, 1 << 30);
        wait_done(20);
        start_fill(800, 0, 4, 4, 32'h2, 32'h0, 1 << 30);
        wait_done(20);
        start_fill(0, 600, 4, 4, 32'h3, 32'h0, 1 << 30);
        wait_done(20);

        // Randomised rectangles, biased toward the screen edges.
        for (int i = 0; i < 10; i++) begin
            int rx, ry;
            ready_mode = int'($urandom_range(0, 1));
            rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(790, 805)) : int'($urandom_range(0, 1023));
            ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(592, 605)) : int'($urandom_range(0, 1023));
            start_fill(rx, ry, int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                       $urandom, $urandom, 1 << 30);
            wait_done(400);
        end

        // Abort: 100x1 fill, ready held low after 5 beats, then abort.
        base       = hs_count;
        hs_limit   = base + 5;
        ready_mode = 2;
        start_fill(0, 3, 100, 1, 32'hCAFE0000, 32'h1, 6);
        n = 0;
        while (hs_count < base + 5 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("abort_beat_pending", 64'(wr_valid && !wr_ready), 64'(1));
        cfg_write(3'd0, 32'h2);
        tick();
        ready_mode = 0;
        wait_done(100);
        check("abort_beat_count", 64'(hs_count - base), 64'(6));
        read_check("abort_status", 3'd1, 32'h6);

        // Abort while idle and start+abort together are both no-ops.
        cfg_write(3'd0, 32'h2);
        check("idle_abort_busy", 64'(busy), 64'(0));
        cfg_write(3'd0, 32'h3);
        check("start_abort_busy", 64'(busy), 64'(0));
        read_check("start_abort_status", 3'd1, 32'h6);

        // Writes while busy are ignored.
        ready_mode = 1;
        col_a = 32'hA5A5_0001;
        start_fill(20, 30, 3, 3, col_a, 32'h0, 1 << 30);
        cfg_write(3'd4, 32'hDEAD_BEEF);
        cfg_write(3'd0, 32'h1);
        cfg_write(3'd2, 32'h0);
        wait_done(200);
        read_check("busy_color_ignored", 3'd4, col_a);
        read_check("busy_origin_ignored", 3'd2, {6'b0, 10'd30, 6'b0, 10'd20});

        // Reset mid-fill.
        ready_mode = 0;
        start_fill(0, 0, 50, 2, 32'h77, 32'h0, 1 << 30);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(wr_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_addr", 64'(wr_addr), 64'h04100000);
        read_check("midrst_status", 3'd1, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        check("midrst_no_beats", 64'(wr_valid), 64'(0));
        check("midrst_queue_flushed", 64'(exp_q.size()), 64'(0));

`ifdef FB_FILL_GRAD_EN
        start_fill(0, 0, 3, 1, 32'h10, 32'hAAA, 1 << 30);
        wait_done(50);
        read_check("grad_step_readback", 3'd5, 32'hAAA);
        start_fill(100, 100, 3, 2, 32'h2, 32'hFFFF_FFFF, 1 << 30);
        wait_done(50);
`else
        cfg_write(3'd5, 32'h1234);
        read_check("step_absent_reads_zero", 3'd5, 32'h0);
        start_fill(0, 0, 3, 1, 32'h10, 32'hAAA, 1 << 30);
        wait_done(50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
